// File: rtl/lcd_bus_ctrl.sv
// ---------------------------------------------------------------------------
// lcd_bus_ctrl
// HD44780-style character-LCD bus controller. Accepts one command/data
// transfer at a time from the LCD command sequencer and sequences the panel
// RS/RW/EN/data lines with programmable setup, enable, hold and execution
// times. Supports 8-bit and 4-bit bus modes, writes and reads (busy flag or
// DDRAM/CGRAM data). Clear/home commands get a long execution wait.
//
// Ports
//   iCLK, iRST      : clock, synchronous active-high reset
//   iDATA/iRS/iRW   : byte, register select and direction, latched on iStart
//   iStart/oReady   : request handshake (iStart only looked at while oReady)
//   oDone           : one-cycle pulse at the end of each transfer
//   oRDATA          : byte returned by the last read
//   LCD_DATA_O/_OE  : panel data out and drive enable (tristate is external)
//   LCD_DATA_I      : panel data in
//   LCD_RW/RS/EN    : panel control lines
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module lcd_bus_ctrl #(
    parameter int DATA_MODE   = 8,
    parameter int T_SETUP     = 2,
    parameter int T_EN        = 16,
    parameter int T_HOLD      = 2,
    parameter int T_EXEC      = 2000,
    parameter int T_EXEC_LONG = 80000,
    parameter int CNT_W       = 17
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic [7:0] iDATA,
    input  logic       iRS,
    input  logic       iRW,
    input  logic       iStart,
    output logic       oReady,
    output logic       oDone,
    output logic [7:0] oRDATA,
    output logic [7:0] LCD_DATA_O,
    output logic       LCD_DATA_OE,
    input  logic [7:0] LCD_DATA_I,
    output logic       LCD_RW,
    output logic       LCD_RS,
    output logic       LCD_EN
);

    localparam logic             FOUR_BIT = (DATA_MODE == 4) ? 1'b1 : 1'b0;
    // Counter reload values: a phase of N cycles counts N-1 down to 0.
    localparam logic [CNT_W-1:0] C_SETUP  = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] C_EN     = CNT_W'(T_EN - 1);
    localparam logic [CNT_W-1:0] C_HOLD   = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] C_EXEC   = CNT_W'(T_EXEC - 1);
    localparam logic [CNT_W-1:0] C_EXEC_L = CNT_W'(T_EXEC_LONG - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_EN_HIGH = 3'd2,
        S_HOLD    = 3'd3,
        S_EXEC    = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    // Clear display (0x01) and return home (0x02/0x03) need the long wait;
    // only instruction-register writes qualify.
    function automatic logic is_long_cmd(input logic [7:0] b, input logic rs, input logic rw);
        return (~rs) & (~rw) & ((b == 8'h01) | (b == 8'h02) | (b == 8'h03));
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_cnt_zero;

    // Latched transfer and registered outputs, plus their next values.
    logic [7:0] r_byte,   w_byte_nxt;
    logic       r_rs,     w_rs_nxt;
    logic       r_rw,     w_rw_nxt;
    logic       r_nib,    w_nib_nxt;
    logic       r_ready,  w_ready_nxt;
    logic       r_done,   w_done_nxt;
    logic [7:0] r_rdata,  w_rdata_nxt;
    logic [7:0] r_dout,   w_dout_nxt;
    logic       r_oe,     w_oe_nxt;
    logic       r_en,     w_en_nxt;

    assign w_cnt_zero = (r_cnt == {CNT_W{1'b0}});

    // State register and phase counter.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state <= S_IDLE;
            r_cnt   <= {CNT_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and counter reload logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (iStart) begin
                    w_state_nxt = S_SETUP;
                    w_cnt_nxt   = C_SETUP;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SETUP: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_EN_HIGH;
                    w_cnt_nxt   = C_EN;
                end else begin
                    w_cnt_nxt = r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            S_EN_HIGH: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = C_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            S_HOLD: begin
                if (w_cnt_zero) begin
                    if (FOUR_BIT && !r_nib) begin
                        // second nibble of the same byte
                        w_state_nxt = S_SETUP;
                        w_cnt_nxt   = C_SETUP;
                    end else if (r_rw) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_EXEC;
                        w_cnt_nxt   = is_long_cmd(r_byte, r_rs, r_rw) ? C_EXEC_L : C_EXEC;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            S_EXEC: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Next values of the latched transfer and the registered outputs.
    always_comb begin
        w_byte_nxt  = r_byte;
        w_rs_nxt    = r_rs;
        w_rw_nxt    = r_rw;
        w_nib_nxt   = r_nib;
        w_ready_nxt = r_ready;
        w_done_nxt  = 1'b0;
        w_rdata_nxt = r_rdata;
        w_dout_nxt  = r_dout;
        w_oe_nxt    = r_oe;
        w_en_nxt    = r_en;
        case (r_state)
            S_IDLE: begin
                if (iStart) begin
                    w_byte_nxt  = iDATA;
                    w_rs_nxt    = iRS;
                    w_rw_nxt    = iRW;
                    w_ready_nxt = 1'b0;
                    w_oe_nxt    = ~iRW;
                    w_dout_nxt  = FOUR_BIT ? {iDATA[7:4], 4'h0} : iDATA;
                end else begin
                    w_ready_nxt = 1'b1;
                end
            end
            S_SETUP: begin
                if (w_cnt_zero) begin
                    w_en_nxt = 1'b1;
                end else begin
                    w_en_nxt = 1'b0;
                end
            end
            S_EN_HIGH: begin
                if (w_cnt_zero) begin
                    w_en_nxt = 1'b0;
                    // read data is taken on the edge that drops EN
                    if (r_rw) begin
                        if (!FOUR_BIT) begin
                            w_rdata_nxt = LCD_DATA_I;
                        end else if (!r_nib) begin
                            w_rdata_nxt = {LCD_DATA_I[7:4], r_rdata[3:0]};
                        end else begin
                            w_rdata_nxt = {r_rdata[7:4], LCD_DATA_I[7:4]};
                        end
                    end else begin
                        w_rdata_nxt = r_rdata;
                    end
                end else begin
                    w_en_nxt = 1'b1;
                end
            end
            S_HOLD: begin
                if (w_cnt_zero) begin
                    if (FOUR_BIT && !r_nib) begin
                        w_nib_nxt  = 1'b1;
                        w_dout_nxt = {r_byte[3:0], 4'h0};
                    end else if (r_rw) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_oe_nxt = 1'b0;
                    end
                end else begin
                    w_en_nxt = 1'b0;
                end
            end
            S_EXEC: begin
                if (w_cnt_zero) begin
                    w_done_nxt = 1'b1;
                end else begin
                    w_done_nxt = 1'b0;
                end
            end
            S_DONE: begin
                w_nib_nxt   = 1'b0;
                w_ready_nxt = 1'b1;
            end
            default: begin
                w_nib_nxt   = 1'b0;
                w_ready_nxt = 1'b1;
                w_en_nxt    = 1'b0;
                w_oe_nxt    = 1'b0;
            end
        endcase
    end

    // Output and transfer-latch registers.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_byte  <= 8'h00;
            r_rs    <= 1'b0;
            r_rw    <= 1'b0;
            r_nib   <= 1'b0;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_rdata <= 8'h00;
            r_dout  <= 8'h00;
            r_oe    <= 1'b0;
            r_en    <= 1'b0;
        end else begin
            r_byte  <= w_byte_nxt;
            r_rs    <= w_rs_nxt;
            r_rw    <= w_rw_nxt;
            r_nib   <= w_nib_nxt;
            r_ready <= w_ready_nxt;
            r_done  <= w_done_nxt;
            r_rdata <= w_rdata_nxt;
            r_dout  <= w_dout_nxt;
            r_oe    <= w_oe_nxt;
            r_en    <= w_en_nxt;
        end
    end

    assign oReady      = r_ready;
    assign oDone       = r_done;
    assign oRDATA      = r_rdata;
    assign LCD_DATA_O  = r_dout;
    assign LCD_DATA_OE = r_oe;
    assign LCD_RW      = r_rw;
    assign LCD_RS      = r_rs;
    assign LCD_EN      = r_en;

endmodule

// File: tb/tb_lcd_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lcd_bus_ctrl
// Directed bench for lcd_bus_ctrl. One 8-bit-mode and one 4-bit-mode
// instance share clock, reset and data inputs; each has its own iStart.
// Every transfer is traced cycle by cycle (cycle 0 = first SETUP cycle) and
// the traces are compared with hand-computed timing for
// T_SETUP=2, T_EN=4, T_HOLD=2, T_EXEC=10, T_EXEC_LONG=50 (P=8).
// ---------------------------------------------------------------------------
module tb_lcd_bus_ctrl;

    localparam int NCYC = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       go;
    logic       sel4;
    logic [7:0] din;
    logic       rs;
    logic       rw;
    logic [7:0] pin;

    logic       start_8, start_4;
    logic       ready_8, done_8, oe_8, rw_8, rs_8, en_8;
    logic [7:0] rdata_8, dout_8;
    logic       ready_4, done_4, oe_4, rw_4, rs_4, en_4;
    logic [7:0] rdata_4, dout_4;

    int n_checks = 0;
    int n_errors = 0;

    logic       tr_en    [0:NCYC-1];
    logic       tr_ready [0:NCYC-1];
    logic       tr_oe    [0:NCYC-1];
    logic       tr_rw    [0:NCYC-1];
    logic       tr_rs    [0:NCYC-1];
    logic [7:0] tr_dout  [0:NCYC-1];
    logic [7:0] tr_rdata [0:NCYC-1];
    int done_first, done_cnt, en_first, en_last, en_cnt;
    int bad;

    assign start_8 = go & ~sel4;
    assign start_4 = go & sel4;

    always #5 clk = ~clk;

    lcd_bus_ctrl #(
        .DATA_MODE(8), .T_SETUP(2), .T_EN(4), .T_HOLD(2),
        .T_EXEC(10), .T_EXEC_LONG(50), .CNT_W(17)
    ) dut8 (
        .iCLK(clk), .iRST(rst), .iDATA(din), .iRS(rs), .iRW(rw),
        .iStart(start_8), .oReady(ready_8), .oDone(done_8), .oRDATA(rdata_8),
        .LCD_DATA_O(dout_8), .LCD_DATA_OE(oe_8), .LCD_DATA_I(pin),
        .LCD_RW(rw_8), .LCD_RS(rs_8), .LCD_EN(en_8)
    );

    lcd_bus_ctrl #(
        .DATA_MODE(4), .T_SETUP(2), .T_EN(4), .T_HOLD(2),
        .T_EXEC(10), .T_EXEC_LONG(50), .CNT_W(17)
    ) dut4 (
        .iCLK(clk), .iRST(rst), .iDATA(din), .iRS(rs), .iRW(rw),
        .iStart(start_4), .oReady(ready_4), .oDone(done_4), .oRDATA(rdata_4),
        .LCD_DATA_O(dout_4), .LCD_DATA_OE(oe_4), .LCD_DATA_I(pin),
        .LCD_RW(rw_4), .LCD_RS(rs_4), .LCD_EN(en_4)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One transfer on the selected instance. pin_a is presented on the panel
    // bus in cycles 0-7, pin_b from cycle 8 on. iDATA is scrambled from cycle 1
    // on to show the byte is latched. start_at/rst_at pulse iStart/iRST during
    // that cycle (-1 = never).
    task automatic run(input logic four, input logic [7:0] d, input logic r_s,
                       input logic r_w, input logic [7:0] pin_a, input logic [7:0] pin_b,
                       input int start_at, input int rst_at);
        sel4 = four;
        din  = d;
        rs   = r_s;
        rw   = r_w;
        pin  = pin_a;
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        done_first = -1; done_cnt = 0;
        en_first = -1; en_last = -1; en_cnt = 0;
        for (int c = 0; c < NCYC; c++) begin
            tr_en[c]    = four ? en_4    : en_8;
            tr_ready[c] = four ? ready_4 : ready_8;
            tr_oe[c]    = four ? oe_4    : oe_8;
            tr_rw[c]    = four ? rw_4    : rw_8;
            tr_rs[c]    = four ? rs_4    : rs_8;
            tr_dout[c]  = four ? dout_4  : dout_8;
            tr_rdata[c] = four ? rdata_4 : rdata_8;
            if (four ? done_4 : done_8) begin
                done_cnt++;
                if (done_first < 0) done_first = c;
            end
            if (tr_en[c]) begin
                en_cnt++;
                if (en_first < 0) en_first = c;
                en_last = c;
            end
            din = ~d;
            pin = (c >= 7) ? pin_b : pin_a;
            go  = (c == start_at) ? 1'b1 : 1'b0;
            rst = (c == rst_at) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        go  = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; go = 1'b0; sel4 = 1'b0;
        din = 8'h00; rs = 1'b0; rw = 1'b0; pin = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // reset state
        chk("rst_ready", int'(ready_8), 1);
        chk("rst_done", int'(done_8), 0);
        chk("rst_rdata", int'(rdata_8), 0);
        chk("rst_dout", int'(dout_8), 0);
        chk("rst_oe", int'(oe_8), 0);
        chk("rst_ctl", int'({rw_8, rs_8, en_8}), 0);
        chk("rst_ready4", int'(ready_4), 1);

        // 8-bit data write 0x41
        run(1'b0, 8'h41, 1'b1, 1'b0, 8'h00, 8'h00, -1, -1);
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            if (tr_dout[c] !== 8'h41 || tr_oe[c] !== 1'b1) bad++;
        end
        chk("w8_bus_c0_7", bad, 0);
        chk("w8_oe_exec", int'(tr_oe[8]), 0);
        chk("w8_rs", int'(tr_rs[0]), 1);
        chk("w8_rw", int'(tr_rw[0]), 0);
        chk("w8_en_first", en_first, 2);
        chk("w8_en_last", en_last, 5);
        chk("w8_en_cnt", en_cnt, 4);
        chk("w8_done_cyc", done_first, 18);
        chk("w8_done_cnt", done_cnt, 1);
        chk("w8_busy_c0", int'(tr_ready[0]), 0);
        chk("w8_busy_c18", int'(tr_ready[18]), 0);
        chk("w8_ready_c19", int'(tr_ready[19]), 1);

        // execution wait selection
        run(1'b0, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00, -1, -1);
        chk("clr_done_cyc", done_first, 58);
        run(1'b0, 8'h01, 1'b1, 1'b0, 8'h00, 8'h00, -1, -1);
        chk("data01_done_cyc", done_first, 18);
        run(1'b0, 8'h04, 1'b0, 1'b0, 8'h00, 8'h00, -1, -1);
        chk("cmd04_done_cyc", done_first, 18);
        run(1'b0, 8'h03, 1'b0, 1'b0, 8'h00, 8'h00, -1, -1);
        chk("home03_done_cyc", done_first, 58);

        // 4-bit write 0xA5
        run(1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 8'h00, -1, -1);
        bad = 0;
        for (int c = 0; c < 30; c++) begin
            if (tr_en[c] !== (((c >= 2) && (c <= 5)) || ((c >= 10) && (c <= 13)))) bad++;
        end
        chk("w4_en_pattern", bad, 0);
        chk("w4_en_cnt", en_cnt, 8);
        chk("w4_hi_nib", int'(tr_dout[0]), 32'hA0);
        chk("w4_lo_nib", int'(tr_dout[8]), 32'h50);
        chk("w4_lo_nib_end", int'(tr_dout[15]), 32'h50);
        chk("w4_oe_c15", int'(tr_oe[15]), 1);
        chk("w4_done_cyc", done_first, 26);

        // 8-bit read
        run(1'b0, 8'h00, 1'b0, 1'b1, 8'h80, 8'h80, -1, -1);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            if (tr_oe[c] !== 1'b0) bad++;
        end
        chk("r8_oe_low", bad, 0);
        chk("r8_rw", int'(tr_rw[0]), 1);
        chk("r8_done_cyc", done_first, 8);
        chk("r8_rdata", int'(tr_rdata[8]), 32'h80);

        // 4-bit read: nibbles 0x3 then 0xC, low panel bits must be ignored
        run(1'b1, 8'h00, 1'b1, 1'b1, 8'h3F, 8'hC5, -1, -1);
        chk("r4_done_cyc", done_first, 16);
        chk("r4_rdata", int'(tr_rdata[16]), 32'h3C);
        chk("r4_rdata_hold", int'(tr_rdata[40]), 32'h3C);

        // iStart during a transfer is ignored
        run(1'b0, 8'h55, 1'b1, 1'b0, 8'h00, 8'h00, 5, -1);
        chk("ign_done_cnt", done_cnt, 1);
        chk("ign_done_cyc", done_first, 18);

        // reset while EN is high abandons the transfer
        run(1'b0, 8'h66, 1'b1, 1'b0, 8'h00, 8'h00, -1, 3);
        chk("rst_en_c3", int'(tr_en[3]), 1);
        chk("rst_en_c4", int'(tr_en[4]), 0);
        chk("rst_ready_c4", int'(tr_ready[4]), 1);
        chk("rst_no_done", done_cnt, 0);
        run(1'b0, 8'h42, 1'b1, 1'b0, 8'h00, 8'h00, -1, -1);
        chk("post_rst_dout", int'(tr_dout[0]), 32'h42);
        chk("post_rst_done", done_first, 18);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
